// File: rtl/lut_loader_x4_4b_i8_pkg.sv
// rtl/lut_loader_x4_4b_i8_pkg.sv - LUT geometry, entry type and loader state enum shared with the burst-read table
package lut_loader_x4_4b_i8_pkg;

  localparam int LUT_ROWS = 36;
  localparam int LUT_COLS = 16;
  localparam int ROW_W    = 6;

  typedef logic signed [7:0] lut_entry_t;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FILL   = 3'd1,
    ST_COMMIT = 3'd2,
    ST_DONE   = 3'd3,
    ST_ERR    = 3'd4
  } load_state_e;

  // A load is legal when it moves at least one row and stays inside the table.
  function automatic logic load_range_ok(input logic [ROW_W-1:0] base,
                                         input logic [ROW_W-1:0] rows,
                                         input int               n_rows);
    logic [ROW_W:0] end_row;
    end_row = {1'b0, base} + {1'b0, rows};
    return (rows != '0) && ({{(32-ROW_W-1){1'b0}}, end_row} <= 32'(n_rows));
  endfunction

endpackage

// File: rtl/lut_loader_x4_4b_i8_if.sv
// rtl/lut_loader_x4_4b_i8_if.sv - byte stream in and row write port out of the LUT loader
interface lut_loader_x4_4b_i8_if #(
  parameter int COLS = lut_loader_x4_4b_i8_pkg::LUT_COLS
);
  import lut_loader_x4_4b_i8_pkg::*;

  logic                   s_valid;
  lut_entry_t             s_data;
  logic                   s_ready;
  logic                   wr_en;
  logic [ROW_W-1:0]       wr_row;
  lut_entry_t [COLS-1:0]  wr_data;

  modport master (
    output s_valid, s_data,
    input  s_ready, wr_en, wr_row, wr_data
  );

  modport slave (
    input  s_valid, s_data,
    output s_ready, wr_en, wr_row, wr_data
  );

endinterface

// File: rtl/lut_loader_x4_4b_i8_row_packer.sv
// rtl/lut_loader_x4_4b_i8_row_packer.sv - lut_row_packer: column counter and one-row assembly buffer
module lut_row_packer
  import lut_loader_x4_4b_i8_pkg::*;
#(
  parameter  int COLS = LUT_COLS,
  localparam int CW   = $clog2(COLS + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  push,
  input  lut_entry_t            push_data,
  output logic                  last_beat,
  output logic                  full,
  output lut_entry_t [COLS-1:0] row_next
);

  localparam logic [CW-1:0] LAST_COL = CW'(COLS - 1);
  localparam logic [CW-1:0] FULL_COL = CW'(COLS);

  logic [CW-1:0]         col_q, col_d;
  lut_entry_t [COLS-1:0] row_q, row_d;

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    for (int i = 0; i < COLS; i++) begin
      if (push && (col_q == CW'(i))) row_d[i] = push_data;
    end
    // Clear wins so an abort on the same cycle as a push drops the partial row.
    if (clear)     col_d = '0;
    else if (push) col_d = col_q + CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

  assign last_beat = push && (col_q == LAST_COL);
  assign full      = (col_q == FULL_COL);
  assign row_next  = row_d;

endmodule

// File: rtl/lut_loader_x4_4b_i8.sv
// rtl/lut_loader_x4_4b_i8.sv - streams signed bytes into whole-row LUT writes with range check, abort and checksum
module lut_loader_x4_4b_i8
  import lut_loader_x4_4b_i8_pkg::*;
#(
  parameter int ROWS = LUT_ROWS,
  parameter int COLS = LUT_COLS
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load_start,
  input  logic [ROW_W-1:0]        load_base_row,
  input  logic [ROW_W-1:0]        load_rows,
  input  logic                    load_abort,
  lut_loader_x4_4b_i8_if.slave    lb,
  output logic                    load_busy,
  output logic                    load_done,
  output logic                    load_err,
  output logic [15:0]             checksum
);

  load_state_e           state_q, state_d;
  logic [ROW_W-1:0]      row_ptr_q, row_ptr_d;
  logic [ROW_W-1:0]      remain_q, remain_d;
  logic [ROW_W-1:0]      wr_row_q, wr_row_d;
  lut_entry_t [COLS-1:0] wr_data_q, wr_data_d;
  logic [15:0]           checksum_q, checksum_d;

  lut_entry_t [COLS-1:0] row_next;
  logic                  hs;
  logic                  row_last;
  logic                  row_full;
  logic                  pk_clear;

  assign hs       = lb.s_valid && lb.s_ready;
  assign pk_clear = (state_q != ST_FILL) || load_abort;

  lut_row_packer #(.COLS(COLS)) u_packer (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (pk_clear),
    .push      (hs),
    .push_data (lb.s_data),
    .last_beat (row_last),
    .full      (row_full),
    .row_next  (row_next)
  );

  always_comb begin
    state_d    = state_q;
    row_ptr_d  = row_ptr_q;
    remain_d   = remain_q;
    wr_row_d   = wr_row_q;
    wr_data_d  = wr_data_q;
    checksum_d = checksum_q;
    case (state_q)
      ST_IDLE: begin
        if (load_start) begin
          if (load_range_ok(load_base_row, load_rows, ROWS)) begin
            state_d    = ST_FILL;
            row_ptr_d  = load_base_row;
            remain_d   = load_rows;
            checksum_d = '0;
          end else begin
            state_d = ST_ERR;
          end
        end
      end
      ST_FILL: begin
        if (load_abort) begin
          state_d = ST_IDLE;
        end else begin
          if (hs) checksum_d = checksum_q + {{8{lb.s_data[7]}}, lb.s_data};
          // Capture the finished row (including this beat) so wr_data is stable through COMMIT.
          if (row_last) begin
            state_d   = ST_COMMIT;
            wr_row_d  = row_ptr_q;
            wr_data_d = row_next;
          end
        end
      end
      ST_COMMIT: begin
        if (load_abort) begin
          state_d = ST_IDLE;
        end else begin
          row_ptr_d = row_ptr_q + ROW_W'(1);
          remain_d  = remain_q - ROW_W'(1);
          state_d   = (remain_q == ROW_W'(1)) ? ST_DONE : ST_FILL;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      ST_ERR:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      row_ptr_q  <= '0;
      remain_q   <= '0;
      wr_row_q   <= '0;
      wr_data_q  <= '0;
      checksum_q <= '0;
    end else begin
      state_q    <= state_d;
      row_ptr_q  <= row_ptr_d;
      remain_q   <= remain_d;
      wr_row_q   <= wr_row_d;
      wr_data_q  <= wr_data_d;
      checksum_q <= checksum_d;
    end
  end

  assign lb.s_ready = (state_q == ST_FILL);
  assign lb.wr_en   = (state_q == ST_COMMIT) && row_full && !load_abort;
  assign lb.wr_row  = wr_row_q;
  assign lb.wr_data = wr_data_q;

  assign load_busy = (state_q == ST_FILL) || (state_q == ST_COMMIT) || (state_q == ST_DONE);
  assign load_done = (state_q == ST_DONE);
  assign load_err  = (state_q == ST_ERR);
  assign checksum  = checksum_q;

endmodule

// File: tb/tb_lut_loader_x4_4b_i8.sv
// tb/tb_lut_loader_x4_4b_i8.sv - directed loads checked against a row/checksum model of the loader
module tb_lut_loader_x4_4b_i8;

  localparam int COLS = 16;

  typedef struct packed {
    logic [5:0]   row;
    logic [127:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        load_start;
  logic [5:0]  load_base_row;
  logic [5:0]  load_rows;
  logic        load_abort;
  logic        busy, done, err;
  logic [15:0] checksum;

  lut_loader_x4_4b_i8_if #(.COLS(COLS)) lb ();

  lut_loader_x4_4b_i8 dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .load_start    (load_start),
    .load_base_row (load_base_row),
    .load_rows     (load_rows),
    .load_abort    (load_abort),
    .lb            (lb.slave),
    .load_busy     (busy),
    .load_done     (done),
    .load_err      (err),
    .checksum      (checksum)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  // model state written by the driver
  wr_t         exp_q[$];
  logic [7:0]  tx_q[$];
  logic [15:0] exp_ck = '0;
  int          exp_done = 0;
  int          exp_err = 0;
  int          first_hs_cyc = 0;

  // observations written by the compare process
  int           got_done = 0;
  int           got_err = 0;
  int           n_wr = 0;
  int           last_wr_cyc = 0;
  int           prev_wr_cyc = 0;
  int           last_done_cyc = 0;
  logic [5:0]   last_wr_row = '0;
  logic [127:0] last_wr_data = '0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] want);
    n_vec++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (lb.wr_en) begin
        wr_t e;
        n_wr++;
        prev_wr_cyc  = last_wr_cyc;
        last_wr_cyc  = cyc;
        last_wr_row  = lb.wr_row;
        last_wr_data = lb.wr_data;
        chk("wr_expected", 128'(exp_q.size() != 0), 128'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("wr_row", 128'(lb.wr_row), 128'(e.row));
          chk("wr_data", lb.wr_data, e.data);
        end
      end
      if (done) begin
        chk("done_expected", 128'(got_done < exp_done), 128'd1);
        chk("done_checksum", 128'(checksum), 128'(exp_ck));
        got_done++;
        last_done_cyc = cyc;
      end
      if (err) begin
        chk("err_expected", 128'(got_err < exp_err), 128'd1);
        got_err++;
      end
      chk("ready_implies_busy", 128'(!(lb.s_ready && !busy)), 128'd1);
      chk("done_err_exclusive", 128'(!(done && err)), 128'd1);
    end
  end

  // Queue the rows that will be completed and the checksum of a finished load, then drive it.
  task automatic run_load(input int base, input int rows, input bit gaps,
                          input int abort_after, input bit mid_start);
    int   idx;
    int   budget;
    int   limit;
    bit   acc;
    bit   sent2;
    int   done0;
    wr_t  e;
    idx = 0; budget = 0; sent2 = 0;
    done0 = exp_done;
    for (int r = 0; r < rows; r++) begin
      if (abort_after < 0 || (r + 1) * COLS < abort_after) begin
        e.row  = 6'(base + r);
        e.data = '0;
        for (int i = 0; i < COLS; i++) e.data[8*i +: 8] = tx_q[r*COLS + i];
        exp_q.push_back(e);
      end
    end
    exp_ck = '0;
    foreach (tx_q[i]) exp_ck = exp_ck + {{8{tx_q[i][7]}}, tx_q[i]};
    if (abort_after < 0) exp_done = done0 + 1;
    limit = (abort_after < 0) ? rows * COLS : abort_after;

    load_base_row = 6'(base);
    load_rows     = 6'(rows);
    load_start    = 1'b1;
    tick();
    load_start = 1'b0;
    while (idx < limit && budget < 3000) begin
      lb.s_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      lb.s_data  = tx_q[idx];
      if (mid_start && idx == COLS / 2 && !sent2) begin
        load_start = 1'b1; load_base_row = 6'd0; load_rows = 6'd1; sent2 = 1;
      end
      @(negedge clk);
      acc = lb.s_valid && lb.s_ready;
      if (acc && idx == 0) first_hs_cyc = cyc;
      tick();
      load_start = 1'b0;
      if (acc) idx++;
      budget++;
    end
    lb.s_valid = 1'b0;
    chk("stream_in_budget", 128'(budget < 3000), 128'd1);
    if (abort_after >= 0) begin
      load_abort = 1'b1;
      tick();
      load_abort = 1'b0;
    end
    for (int k = 0; k < 8 && busy; k++) tick();
    chk("load_idle", 128'(busy), 128'd0);
    chk("all_rows_written", 128'(exp_q.size()), 128'd0);
    chk("done_count", 128'(got_done), 128'(exp_done));
  endtask

  task automatic run_err(input int base, input int rows);
    int w0;
    int e0;
    w0 = n_wr;
    e0 = got_err;
    exp_err++;
    load_base_row = 6'(base);
    load_rows     = 6'(rows);
    load_start    = 1'b1;
    lb.s_valid    = 1'b1;
    tick();
    load_start = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("err_no_ready", 128'(lb.s_ready), 128'd0);
      tick();
    end
    lb.s_valid = 1'b0;
    chk("err_pulse_once", 128'(got_err - e0), 128'd1);
    chk("err_no_write", 128'(n_wr - w0), 128'd0);
  endtask

  task automatic check_reset_outputs();
    chk("rst_s_ready", 128'(lb.s_ready), 128'd0);
    chk("rst_wr_en", 128'(lb.wr_en), 128'd0);
    chk("rst_busy", 128'(busy), 128'd0);
    chk("rst_done", 128'(done), 128'd0);
    chk("rst_err", 128'(err), 128'd0);
    chk("rst_wr_row", 128'(lb.wr_row), 128'd0);
    chk("rst_wr_data", lb.wr_data, 128'd0);
    chk("rst_checksum", 128'(checksum), 128'd0);
  endtask

  initial begin
    int w0;
    int d0;
    rst_n = 1'b0;
    load_start = 1'b0; load_abort = 1'b0;
    load_base_row = '0; load_rows = '0;
    lb.s_valid = 1'b0; lb.s_data = '0;
    repeat (3) tick();
    @(negedge clk);
    check_reset_outputs();
    tick();
    rst_n = 1'b1;
    tick();

    // one row, bytes 1..16
    tx_q.delete();
    for (int i = 0; i < COLS; i++) tx_q.push_back(8'(i + 1));
    run_load(0, 1, 0, -1, 0);
    chk("t1_wr_latency", 128'(last_wr_cyc - first_hs_cyc), 128'd16);
    chk("t1_done_after_wr", 128'(last_done_cyc - last_wr_cyc), 128'd1);
    chk("t1_wr_row", 128'(last_wr_row), 128'd0);
    chk("t1_wr_data", last_wr_data, 128'h100F0E0D0C0B0A090807060504030201);
    chk("t1_checksum", 128'(checksum), 128'h0088);

    // last two rows of the table, all 0xFF
    tx_q.delete();
    for (int i = 0; i < 2 * COLS; i++) tx_q.push_back(8'hFF);
    run_load(34, 2, 0, -1, 0);
    chk("t2_last_row", 128'(last_wr_row), 128'd35);
    chk("t2_row_period", 128'(last_wr_cyc - prev_wr_cyc), 128'd17);
    chk("t2_checksum", 128'(checksum), 128'hFFE0);

    // illegal ranges
    run_err(30, 7);
    run_err(0, 0);
    run_err(35, 2);

    // gapped stream with an ignored second start
    tx_q.delete();
    for (int i = 0; i < 2 * COLS; i++) tx_q.push_back(8'(i * 37 + 5));
    run_load(5, 2, 1, -1, 1);
    chk("t4_last_row", 128'(last_wr_row), 128'd6);

    // abort after 20 bytes keeps row 0 only
    w0 = n_wr;
    d0 = got_done;
    tx_q.delete();
    for (int i = 0; i < 3 * COLS; i++) tx_q.push_back(8'(8'h80 + i));
    run_load(0, 3, 0, 20, 0);
    chk("t5_one_row_written", 128'(n_wr - w0), 128'd1);
    chk("t5_row0", 128'(last_wr_row), 128'd0);
    chk("t5_no_done", 128'(got_done - d0), 128'd0);
    tx_q.delete();
    for (int i = 0; i < COLS; i++) tx_q.push_back(8'(i - 8));
    run_load(20, 1, 0, -1, 0);
    chk("t5_reload_row", 128'(last_wr_row), 128'd20);

    // reset in the middle of a fill
    load_base_row = 6'd0; load_rows = 6'd2; load_start = 1'b1;
    tick();
    load_start = 1'b0;
    lb.s_valid = 1'b1; lb.s_data = 8'h55;
    repeat (5) tick();
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_outputs();
    tick();
    rst_n = 1'b1;
    w0 = n_wr;
    repeat (30) tick();
    @(negedge clk);
    chk("t6_no_ready_after_rst", 128'(lb.s_ready), 128'd0);
    chk("t6_no_write_after_rst", 128'(n_wr - w0), 128'd0);
    tick();
    lb.s_valid = 1'b0;
    tx_q.delete();
    for (int i = 0; i < COLS; i++) tx_q.push_back(8'(8'hF0 ^ i));
    run_load(10, 1, 0, -1, 0);
    chk("t6_reload_row", 128'(last_wr_row), 128'd10);

    chk("err_total", 128'(got_err), 128'(exp_err));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
